// File: rtl/weight_flip_apply_pkg.sv
// bitnet_pkg: shared defaults and flip-apply FSM state type
package bitnet_pkg;
  localparam int DEF_W_SIZE = 1024;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_RD_LAT = 2;
  typedef enum logic [2:0] {IDLE, SCAN, WAIT, WRITE, DONE} flip_state_t;
endpackage

// File: rtl/weight_flip_apply_if.sv
// weight_flip_apply_if: mask handshake, status and weight BRAM port bundle
interface weight_flip_apply_if import bitnet_pkg::*; #(
  parameter int W_SIZE = DEF_W_SIZE,
  parameter int WORD_W = DEF_WORD_W
);
  localparam int NUM_WORDS = W_SIZE / WORD_W;
  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(W_SIZE + 1);
  logic flip_valid_in;
  logic [W_SIZE-1:0] flip_mask_in;
  logic flip_ready_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic mem_we_out;
  logic [WORD_W-1:0] mem_wdata_out;
  logic [WORD_W-1:0] mem_rdata_in;
  logic busy_out;
  logic done_out;
  logic [CNT_W-1:0] flip_count_out;
  modport master (
    output flip_valid_in, flip_mask_in, mem_rdata_in,
    input flip_ready_out, mem_addr_out, mem_we_out, mem_wdata_out, busy_out, done_out, flip_count_out
  );
  modport slave (
    input flip_valid_in, flip_mask_in, mem_rdata_in,
    output flip_ready_out, mem_addr_out, mem_we_out, mem_wdata_out, busy_out, done_out, flip_count_out
  );
endinterface

// File: rtl/weight_flip_apply_popcount.sv
// popcount: combinational count of set bits in a word
module popcount #(
  parameter int WIDTH = 32,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [OUT_W-1:0] o_count
);
  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) o_count = o_count + OUT_W'(i_data[i]);
  end
endmodule

// File: rtl/weight_flip_apply.sv
// weight_flip_apply: XOR a sparse flip mask into a word-organised weight BRAM, skipping all-zero words
module weight_flip_apply import bitnet_pkg::*; #(
  parameter int W_SIZE = DEF_W_SIZE,
  parameter int WORD_W = DEF_WORD_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input logic clk_in,
  input logic rst_in,
  weight_flip_apply_if.slave bus
);
  localparam int NUM_WORDS = W_SIZE / WORD_W;
  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int CNT_W = $clog2(W_SIZE + 1);
  localparam int PC_W = $clog2(WORD_W + 1);
  localparam int LAT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  flip_state_t r_state, w_nxt;
  logic [W_SIZE-1:0] r_mask;
  logic [ADDR_W-1:0] r_idx;
  logic [LAT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_count;
  logic [WORD_W-1:0] w_slice;
  logic [PC_W-1:0] w_pop;
  logic w_last, w_zero;
  assign w_slice = r_mask[r_idx*WORD_W +: WORD_W];
  assign w_last = r_idx == ADDR_W'(NUM_WORDS - 1);
  assign w_zero = w_slice == '0;
  popcount #(.WIDTH(WORD_W)) u_pop (.i_data(w_slice), .o_count(w_pop));
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = bus.flip_valid_in ? SCAN : IDLE;
      SCAN:    w_nxt = w_zero ? (w_last ? DONE : SCAN) : (RD_LAT > 1 ? WAIT : WRITE);
      WAIT:    w_nxt = r_wcnt == '0 ? WRITE : WAIT;
      WRITE:   w_nxt = w_last ? DONE : SCAN;
      default: w_nxt = IDLE;
    endcase
    bus.flip_ready_out = r_state == IDLE;
    bus.busy_out = r_state inside {SCAN, WAIT, WRITE};
    bus.done_out = r_state == DONE;
    bus.mem_we_out = r_state == WRITE;
    bus.mem_addr_out = r_idx;
    bus.mem_wdata_out = r_state == WRITE ? bus.mem_rdata_in ^ w_slice : '0;
    bus.flip_count_out = r_count;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_mask <= '0;
      r_idx <= '0;
      r_wcnt <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && bus.flip_valid_in) begin
        r_mask <= bus.flip_mask_in;
        r_idx <= '0;
        r_count <= '0;
      end
      if (r_state == SCAN) r_wcnt <= LAT_W'(RD_LAT - 2);
      if (r_state == SCAN && w_zero && !w_last) r_idx <= r_idx + 1'b1;
      if (r_state == WAIT) r_wcnt <= r_wcnt - 1'b1;
      if (r_state == WRITE) begin
        r_count <= r_count + CNT_W'(w_pop);
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule

// File: doc/weight_flip_apply.md
Name: weight_flip_apply

Overview:
- Consumes the sparse flip mask produced by the stochastic-gradient sparsifier.
- Applies the mask to the binary weight store by read-modify-write (XOR) over a word-organised BRAM.
- Words whose mask slice is all-zero are skipped without a memory access.
- Sits between the gradient/sparsify stage and the weight BRAM port used for training updates.

Parameters:
- W_SIZE, 1024, total weight bits per mask (must be a multiple of WORD_W).
- WORD_W, 32, BRAM data width; one word holds WORD_W weights.
- RD_LAT, 2, BRAM read latency in cycles (>=1); rdata is valid RD_LAT cycles after the address is presented.
- Derived, localparam: NUM_WORDS = W_SIZE/WORD_W.
- Derived, localparam: ADDR_W = $clog2(NUM_WORDS).
- Derived, localparam: CNT_W = $clog2(W_SIZE+1).

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  synchronous, active-high reset.
- flip_valid_in  input  1  flip_mask_in is valid.
- flip_mask_in  input  W_SIZE  1 = toggle that weight bit; bit i maps to word i/WORD_W, bit i%WORD_W.
- flip_ready_out  output  1  block is idle and can accept a mask.
- mem_addr_out  output  ADDR_W  BRAM word address.
- mem_we_out  output  1  BRAM write enable.
- mem_wdata_out  output  WORD_W  BRAM write data.
- mem_rdata_in  input  WORD_W  BRAM read data.
- busy_out  output  1  update in progress.
- done_out  output  1  one-cycle pulse when the whole mask has been applied.
- flip_count_out  output  CNT_W  number of bits toggled in the last/current update.

Behaviour:
- Reset values: flip_ready_out=1, busy_out=0, done_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0, flip_count_out=0; state=IDLE; internal mask register and word index cleared.
- Reset mid-operation: aborts immediately. mem_we_out is 0 from the next edge. Words already written stay written; the in-flight word is not written.
- States: IDLE, SCAN, WAIT, WRITE, DONE.
- IDLE:
  - flip_ready_out=1.
  - On flip_valid_in&&flip_ready_out: latch mask, idx=0, flip_count_out=0, go to SCAN.
  - flip_valid_in while not in IDLE is ignored; the mask is not re-sampled.
- SCAN (one cycle per word):
  - mem_addr_out=idx, mem_we_out=0.
  - If slice[idx] == 0: if idx==NUM_WORDS-1 go to DONE, else idx++ and stay in SCAN.
  - If slice[idx] != 0: go to WAIT if RD_LAT>1, else directly to WRITE.
- WAIT: hold mem_addr_out; lasts RD_LAT-1 cycles (counter), then go to WRITE.
- WRITE (one cycle):
  - mem_we_out=1, mem_addr_out=idx, mem_wdata_out = mem_rdata_in ^ slice[idx].
  - flip_count_out += popcount(slice[idx]).
  - Then DONE if idx==NUM_WORDS-1, else idx++ and go to SCAN.
- DONE: done_out=1 for exactly one cycle, busy_out=0, go to IDLE. flip_count_out holds until the next accept.
- busy_out=1 in SCAN, WAIT and WRITE.
- Latency per update: accept cycle + Z + N*(RD_LAT+1) + 1 (DONE), where Z = zero words and N = nonzero words (Z+N = NUM_WORDS).
- Back-to-back masks: the earliest next accept is the cycle after DONE (IDLE). No overlap between updates.
- Write data must use rdata sampled exactly RD_LAT cycles after the address first appeared. Address is held stable through WAIT and WRITE.
- Arithmetic: flip_count_out accumulates unsigned at CNT_W; it cannot overflow, since the maximum is W_SIZE.

Decomposition:
- Shared package bitnet_pkg holds W_SIZE/WORD_W defaults and the state enum typedef flip_state_t {IDLE,SCAN,WAIT,WRITE,DONE}.
- One sub-module: popcount #(WIDTH=WORD_W), combinational, output $clog2(WIDTH+1) bits.
- Mask slice selection is an indexed part-select of the latched mask register; no extra module.

Test Plan:
- Single bit: mask bit 37 set, word1 preloaded 0x0000_0000 -> exactly one write to addr 1 with data 0x0000_0020; flip_count_out=1; done_out after 1+31+3+1 cycles (RD_LAT=2).
- Empty mask: all zero -> no mem_we_out pulses; done_out exactly 32 SCAN cycles after accept; flip_count_out=0.
- All ones: every word preloaded 0xA5A5_A5A5 -> 32 writes of 0x5A5A_5A5A at addrs 0..31 in order; flip_count_out=1024.
- Last word only: mask bits 1023 and 992 set, word31=0xFFFF_FFFF -> single write addr 31 data 0x7FFF_FFFE; wrap/end handling goes to DONE, not addr 0.
- Reset mid-update: all-ones mask, assert rst_in during word 5's WAIT -> no write to addr 5; words 0-4 updated, 5-31 untouched; outputs at reset values next cycle.
- Busy rejection and back-to-back: hold flip_valid_in high with a second mask during an update -> second mask accepted only in the IDLE cycle after done_out; flip_ready_out=0 throughout busy.
